// File: rtl/riscv_multicycle_core.sv
`default_nettype none
// ============================================================================
// Module  : riscv_multicycle_core
// Brief   : Multi-cycle RV32I-subset core (FETCH/DECODE/EXECUTE/MEM/WB) with
//           internal register file and data memory. Optional performance
//           counters are compiled in with the RISCV_MC_PERF_EN macro.
// Revision: 1.0 - initial release
// ============================================================================
module riscv_multicycle_core #(
  parameter int               XLEN       = 32,
  parameter int               NUM_REGS   = 32,
  parameter int               DMEM_DEPTH = 64,
  parameter logic [XLEN-1:0]  RESET_PC   = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     instruction,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] write_data,
  output logic            busy,
  output logic            illegal
`ifdef RISCV_MC_PERF_EN
  ,
  output logic [XLEN-1:0] cycle_count,
  output logic [XLEN-1:0] instret_count
`endif
);

  localparam int              c_ridx_w    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int              c_midx_w    = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;
  localparam logic [XLEN-1:0] c_four      = XLEN'(4);
  localparam logic [6:0]      c_op_rtype  = 7'b0110011;
  localparam logic [6:0]      c_op_imm    = 7'b0010011;
  localparam logic [6:0]      c_op_load   = 7'b0000011;
  localparam logic [6:0]      c_op_store  = 7'b0100011;
  localparam logic [6:0]      c_op_branch = 7'b1100011;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    K_ALU     = 3'd0,
    K_LW      = 3'd1,
    K_SW      = 3'd2,
    K_BEQ     = 3'd3,
    K_BNE     = 3'd4,
    K_ILLEGAL = 3'd5
  } kind_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_t;

  // Architectural storage: intentionally not reset
  logic [XLEN-1:0]     r_regs [NUM_REGS];
  logic [XLEN-1:0]     r_dmem [DMEM_DEPTH];

  state_t              r_state;
  kind_t               r_kind;
  alu_op_t             r_alu_op;
  logic [31:0]         r_ir;
  logic [XLEN-1:0]     r_op_a;
  logic [XLEN-1:0]     r_op_b;
  logic [XLEN-1:0]     r_imm_b;
  logic [XLEN-1:0]     r_mdr;
  logic [c_ridx_w-1:0] r_rd;

  logic [6:0]          w_opcode;
  logic [2:0]          w_funct3;
  logic [6:0]          w_funct7;
  logic [c_ridx_w-1:0] w_rs1_idx;
  logic [c_ridx_w-1:0] w_rs2_idx;
  logic [c_ridx_w-1:0] w_rd_idx;
  logic [XLEN-1:0]     w_rs1_val;
  logic [XLEN-1:0]     w_rs2_val;
  logic [XLEN-1:0]     w_imm_i;
  logic [XLEN-1:0]     w_imm_s;
  logic [XLEN-1:0]     w_imm_b;
  logic [XLEN-1:0]     w_op_b;
  kind_t               w_kind;
  alu_op_t             w_alu_op;
  logic [XLEN-1:0]     w_alu;
  logic                w_branch_taken;
  logic [c_midx_w-1:0] w_mem_idx;

  assign instr_ready = (r_state == S_FETCH);
  assign busy        = (r_state != S_FETCH);

  assign w_opcode  = r_ir[6:0];
  assign w_funct3  = r_ir[14:12];
  assign w_funct7  = r_ir[31:25];
  assign w_rd_idx  = r_ir[7 +: c_ridx_w];
  assign w_rs1_idx = r_ir[15 +: c_ridx_w];
  assign w_rs2_idx = r_ir[20 +: c_ridx_w];

  assign w_rs1_val = (w_rs1_idx == '0) ? '0 : r_regs[w_rs1_idx];
  assign w_rs2_val = (w_rs2_idx == '0) ? '0 : r_regs[w_rs2_idx];

  assign w_imm_i = {{(XLEN-12){r_ir[31]}}, r_ir[31:20]};
  assign w_imm_s = {{(XLEN-12){r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
  assign w_imm_b = {{(XLEN-13){r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};

  // Anything not matched below stays K_ILLEGAL
  always_comb begin
    w_kind   = K_ILLEGAL;
    w_alu_op = ALU_ADD;
    w_op_b   = w_rs2_val;
    case (w_opcode)
      c_op_rtype: begin
        if (w_funct7 == 7'b0000000) begin
          case (w_funct3)
            3'b000: begin w_kind = K_ALU; w_alu_op = ALU_ADD; end
            3'b111: begin w_kind = K_ALU; w_alu_op = ALU_AND; end
            3'b110: begin w_kind = K_ALU; w_alu_op = ALU_OR;  end
            3'b010: begin w_kind = K_ALU; w_alu_op = ALU_SLT; end
            default: ;
          endcase
        end else if (w_funct7 == 7'b0100000 && w_funct3 == 3'b000) begin
          w_kind   = K_ALU;
          w_alu_op = ALU_SUB;
        end
      end
      c_op_imm: begin
        if (w_funct3 == 3'b000) begin
          w_kind = K_ALU;
          w_op_b = w_imm_i;
        end
      end
      c_op_load: begin
        if (w_funct3 == 3'b010) begin
          w_kind = K_LW;
          w_op_b = w_imm_i;
        end
      end
      c_op_store: begin
        if (w_funct3 == 3'b010) begin
          w_kind = K_SW;
          w_op_b = w_imm_s;
        end
      end
      c_op_branch: begin
        if (w_funct3 == 3'b000) begin
          w_kind   = K_BEQ;
          w_alu_op = ALU_SUB;
        end else if (w_funct3 == 3'b001) begin
          w_kind   = K_BNE;
          w_alu_op = ALU_SUB;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    case (r_alu_op)
      ALU_SUB: w_alu = r_op_a - r_op_b;
      ALU_AND: w_alu = r_op_a & r_op_b;
      ALU_OR:  w_alu = r_op_a | r_op_b;
      ALU_SLT: w_alu = {{(XLEN-1){1'b0}}, ($signed(r_op_a) < $signed(r_op_b))};
      default: w_alu = r_op_a + r_op_b;
    endcase
  end

  assign w_branch_taken = (r_kind == K_BEQ) ? (r_op_a == r_op_b) : (r_op_a != r_op_b);
  assign w_mem_idx      = alu_result[c_midx_w-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_FETCH;
      pc         <= RESET_PC;
      alu_result <= '0;
      write_data <= '0;
      illegal    <= 1'b0;
      r_ir       <= '0;
      r_kind     <= K_ILLEGAL;
      r_alu_op   <= ALU_ADD;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_imm_b    <= '0;
      r_mdr      <= '0;
      r_rd       <= '0;
    end else begin
      illegal <= 1'b0;
      case (r_state)
        S_FETCH: begin
          if (instr_valid) begin
            r_ir    <= instruction;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_op_a     <= w_rs1_val;
          r_op_b     <= w_op_b;
          write_data <= w_rs2_val;
          r_imm_b    <= w_imm_b;
          r_kind     <= w_kind;
          r_alu_op   <= w_alu_op;
          r_rd       <= w_rd_idx;
          if (w_kind == K_ILLEGAL) begin
            illegal <= 1'b1;
            pc      <= pc + c_four;
            r_state <= S_FETCH;
          end else begin
            r_state <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          alu_result <= w_alu;
          case (r_kind)
            K_BEQ, K_BNE: begin
              pc      <= w_branch_taken ? (pc + r_imm_b) : (pc + c_four);
              r_state <= S_FETCH;
            end
            K_LW, K_SW: r_state <= S_MEM;
            default:    r_state <= S_WB;
          endcase
        end
        S_MEM: begin
          if (r_kind == K_LW) begin
            r_mdr   <= r_dmem[w_mem_idx];
            r_state <= S_WB;
          end else begin
            pc      <= pc + c_four;
            r_state <= S_FETCH;
          end
        end
        S_WB: begin
          pc      <= pc + c_four;
          r_state <= S_FETCH;
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

  // x0 writes dropped here; reads of x0 are forced to zero above
  always_ff @(posedge clk) begin
    if (r_state == S_WB && r_rd != '0) begin
      r_regs[r_rd] <= (r_kind == K_LW) ? r_mdr : alu_result;
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_MEM && r_kind == K_SW) begin
      r_dmem[w_mem_idx] <= write_data;
    end
  end

`ifdef RISCV_MC_PERF_EN
  logic w_retire;

  // Retire on the last state of each legal instruction class
  assign w_retire = (r_state == S_WB) ||
                    (r_state == S_MEM && r_kind == K_SW) ||
                    (r_state == S_EXECUTE && (r_kind == K_BEQ || r_kind == K_BNE));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_count   <= '0;
      instret_count <= '0;
    end else begin
      cycle_count <= cycle_count + XLEN'(1);
      if (w_retire) begin
        instret_count <= instret_count + XLEN'(1);
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_riscv_multicycle_core.sv
`default_nettype none
// ============================================================================
// Module  : tb_riscv_multicycle_core
// Brief   : Self-checking bench for riscv_multicycle_core: directed cases plus
//           randomized instructions against an ISA-level reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_riscv_multicycle_core;

  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic [31:0] alu_result;
  logic [31:0] write_data;
  logic        busy;
  logic        illegal;
`ifdef RISCV_MC_PERF_EN
  logic [31:0] cycle_count;
  logic [31:0] instret_count;
`endif

  riscv_multicycle_core #(
    .XLEN       (32),
    .NUM_REGS   (32),
    .DMEM_DEPTH (64),
    .RESET_PC   (RESET_PC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instruction (instruction),
    .pc          (pc),
    .alu_result  (alu_result),
    .write_data  (write_data),
    .busy        (busy),
    .illegal     (illegal)
`ifdef RISCV_MC_PERF_EN
    ,
    .cycle_count   (cycle_count),
    .instret_count (instret_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: architectural state only
  logic [31:0] m_regs [32];
  logic [31:0] m_mem  [64];
  logic [31:0] m_pc;
  logic [31:0] m_alu;
  logic [31:0] m_wd;
  bit          m_wd_known;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic set_reg(input int i, input logic [31:0] v);
    dut.r_regs[i] = v;
    m_regs[i]     = v;
  endtask

  task automatic set_mem(input int i, input logic [31:0] v);
    dut.r_dmem[i] = v;
    m_mem[i]      = v;
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, input int rs1,
                                        input logic [2:0] f3, input int rd);
    return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input int rs1, input logic [2:0] f3,
                                        input int rd, input logic [6:0] op);
    return {imm, 5'(rs1), f3, 5'(rd), op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input int rs2, input int rs1);
    return {imm[11:5], 5'(rs2), 5'(rs1), 3'b010, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input int rs2, input int rs1,
                                        input logic [2:0] f3);
    return {imm[12], imm[10:5], 5'(rs2), 5'(rs1), f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  // ISA-level effect of one instruction; returns expected latency and illegal flag
  task automatic model_step(input logic [31:0] w, output int lat, output bit ill);
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    int          rd, rs1, rs2, vi, vs, vb;
    logic [31:0] a, b, wval;
    bit          wr;
    op  = w[6:0];   f3 = w[14:12]; f7 = w[31:25];
    rd  = int'(w[11:7]); rs1 = int'(w[19:15]); rs2 = int'(w[24:20]);
    a   = m_regs[rs1];
    b   = m_regs[rs2];
    vi  = int'(w[31:20]);                                   if (w[31]) vi -= 4096;
    vs  = int'({w[31:25], w[11:7]});                        if (w[31]) vs -= 4096;
    vb  = int'({w[31], w[7], w[30:25], w[11:8], 1'b0});     if (w[31]) vb -= 8192;
    ill = 1'b0; wr = 1'b0; lat = 4; wval = '0;
    if (op == 7'b0110011 && f7 == 7'h00 && f3 == 3'b000)      begin m_alu = a + b; wr = 1; end
    else if (op == 7'b0110011 && f7 == 7'h20 && f3 == 3'b000) begin m_alu = a - b; wr = 1; end
    else if (op == 7'b0110011 && f7 == 7'h00 && f3 == 3'b111) begin m_alu = a & b; wr = 1; end
    else if (op == 7'b0110011 && f7 == 7'h00 && f3 == 3'b110) begin m_alu = a | b; wr = 1; end
    else if (op == 7'b0110011 && f7 == 7'h00 && f3 == 3'b010) begin
      m_alu = (int'(a) < int'(b)) ? 32'd1 : 32'd0; wr = 1;
    end
    else if (op == 7'b0010011 && f3 == 3'b000) begin m_alu = a + 32'(vi); wr = 1; end
    else if (op == 7'b0000011 && f3 == 3'b010) begin
      m_alu = a + 32'(vi); wr = 1; lat = 5;
    end
    else if (op == 7'b0100011 && f3 == 3'b010) begin
      m_alu = a + 32'(vs);
      m_mem[m_alu[5:0]] = b;
      m_pc = m_pc + 4;
    end
    else if (op == 7'b1100011 && (f3 == 3'b000 || f3 == 3'b001)) begin
      m_alu = a - b; lat = 3;
      if ((f3 == 3'b000) == (a == b)) m_pc = m_pc + 32'(vb);
      else                            m_pc = m_pc + 4;
    end
    else begin
      ill = 1'b1; lat = 2; m_pc = m_pc + 4;
    end
    if (wr) begin
      wval = (op == 7'b0000011) ? m_mem[m_alu[5:0]] : m_alu;
      if (rd != 0) m_regs[rd] = wval;
      m_pc = m_pc + 4;
    end
    m_wd_known = !ill;
    if (!ill) m_wd = b;
  endtask

  // Present one instruction, check every cycle until the core is ready again,
  // then compare the full architectural state against the model.
  task automatic exec(input logic [31:0] w, output int act_lat, output int ill_cnt);
    int exp_lat;
    bit exp_ill;
    model_step(w, exp_lat, exp_ill);
    instruction = w;
    instr_valid = 1'b1;
    @(posedge clk);
    act_lat = 0;
    ill_cnt = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (illegal) ill_cnt++;
      if (c <= exp_lat) chk("busy", 32'(busy), 32'(c < exp_lat));
      if (instr_ready) begin
        act_lat = c;
        break;
      end
      instr_valid = 1'($urandom_range(0, 1));
      instruction = $urandom;
    end
    instr_valid = 1'b0;
    chk("latency", act_lat, exp_lat);
    chk("illegal_pulses", ill_cnt, 32'(exp_ill));
    @(negedge clk);
    chk("illegal_clear", 32'(illegal), 0);
    chk("ready_idle", 32'(instr_ready), 1);
    chk("pc", pc, m_pc);
    chk("alu_result", alu_result, m_alu);
    if (m_wd_known) chk("write_data", write_data, m_wd);
    for (int i = 1; i < 32; i++) begin
      n_checks++;
      if (dut.r_regs[i] !== m_regs[i]) begin
        n_fail++;
        $display("FAIL reg x%0d actual=%h expected=%h", i, dut.r_regs[i], m_regs[i]);
      end
    end
    for (int i = 0; i < 64; i++) begin
      n_checks++;
      if (dut.r_dmem[i] !== m_mem[i]) begin
        n_fail++;
        $display("FAIL mem[%0d] actual=%h expected=%h", i, dut.r_dmem[i], m_mem[i]);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset       = 1'b1;
    instr_valid = 1'b0;
    #1;
    chk("rst_pc", pc, RESET_PC);
    chk("rst_alu", alu_result, 0);
    chk("rst_wd", write_data, 0);
    chk("rst_illegal", 32'(illegal), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(instr_ready), 1);
    @(negedge clk);
    reset      = 1'b0;
    m_pc       = RESET_PC;
    m_alu      = '0;
    m_wd       = '0;
    m_wd_known = 1'b1;
  endtask

  function automatic logic [31:0] rand_instr();
    int          k;
    int          rd, rs1, rs2;
    logic [11:0] imm;
    logic [12:0] bimm;
    k    = int'($urandom_range(0, 11));
    rd   = int'($urandom_range(0, 31));
    rs1  = int'($urandom_range(0, 31));
    rs2  = int'($urandom_range(0, 31));
    imm  = 12'($urandom);
    bimm = 13'($urandom) & 13'h1ffe;
    case (k)
      0:  return enc_r(7'h00, rs2, rs1, 3'b000, rd);
      1:  return enc_r(7'h20, rs2, rs1, 3'b000, rd);
      2:  return enc_r(7'h00, rs2, rs1, 3'b111, rd);
      3:  return enc_r(7'h00, rs2, rs1, 3'b110, rd);
      4:  return enc_r(7'h00, rs2, rs1, 3'b010, rd);
      5:  return enc_i(imm, rs1, 3'b000, rd, 7'b0010011);
      6:  return enc_i(imm, rs1, 3'b010, rd, 7'b0000011);
      7:  return enc_s(imm, rs2, rs1);
      8, 9: begin
        if ($urandom_range(0, 1) == 1) rs2 = rs1;
        return enc_b(bimm, rs2, rs1, (k == 8) ? 3'b000 : 3'b001);
      end
      10: return $urandom;
      default: return enc_r(7'($urandom), rs2, rs1, 3'($urandom), rd);
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, ic;
    logic [31:0] pc0;
    reset       = 1'b1;
    instr_valid = 1'b0;
    instruction = '0;
    m_regs[0]   = '0;
    for (int i = 1; i < 32; i++) set_reg(i, '0);
    for (int i = 0; i < 64; i++) set_mem(i, '0);
    do_reset();

    // ADD x1,x2,x3
    set_reg(2, 5); set_reg(3, 3);
    exec(enc_r(7'h00, 3, 2, 3'b000, 1), lat, ic);
    chk("add_alu", alu_result, 8);
    chk("add_x1", dut.r_regs[1], 8);
    chk("add_model_x1", m_regs[1], 8);
    chk("add_pc", pc, RESET_PC + 4);
    chk("add_lat", lat, 4);

    set_reg(4, 10); set_reg(5, 4);
    exec(enc_r(7'h20, 5, 4, 3'b000, 6), lat, ic);
    chk("sub_x6", dut.r_regs[6], 6);
    set_reg(7, 6); set_reg(8, 9);
    exec(enc_r(7'h00, 8, 7, 3'b111, 9), lat, ic);
    chk("and_x9", dut.r_regs[9], 0);
    set_reg(10, 7); set_reg(11, 8);
    exec(enc_r(7'h00, 11, 10, 3'b110, 12), lat, ic);
    chk("or_x12", dut.r_regs[12], 15);
    set_reg(13, 32'hFFFF_FFFF); set_reg(14, 1);
    exec(enc_r(7'h00, 14, 13, 3'b010, 15), lat, ic);
    chk("slt_x15", dut.r_regs[15], 1);
    set_reg(16, 99);
    exec(enc_r(7'h00, 3, 2, 3'b000, 0), lat, ic);
    exec(enc_r(7'h00, 0, 0, 3'b000, 16), lat, ic);
    chk("x0_read_zero", dut.r_regs[16], 0);

    // SW x2,4(x1) then LW x4,4(x1)
    set_reg(1, 6); set_reg(2, 123);
    exec(enc_s(12'd4, 2, 1), lat, ic);
    chk("sw_mem10", dut.r_dmem[10], 123);
    chk("sw_lat", lat, 4);
    exec(enc_i(12'd4, 1, 3'b010, 4, 7'b0000011), lat, ic);
    chk("lw_x4", dut.r_regs[4], 123);
    chk("lw_lat", lat, 5);

    // Branches from pc=8
    do_reset();
    set_reg(1, 7); set_reg(2, 7);
    exec(enc_i(12'd0, 0, 3'b000, 0, 7'b0010011), lat, ic);
    exec(enc_i(12'd0, 0, 3'b000, 0, 7'b0010011), lat, ic);
    exec(enc_b(13'd16, 2, 1, 3'b000), lat, ic);
    chk("beq_pc", pc, 24);
    chk("beq_lat", lat, 3);
    do_reset();
    exec(enc_i(12'd0, 0, 3'b000, 0, 7'b0010011), lat, ic);
    exec(enc_i(12'd0, 0, 3'b000, 0, 7'b0010011), lat, ic);
    exec(enc_b(13'd16, 2, 1, 3'b001), lat, ic);
    chk("bne_pc", pc, 12);

    // Illegal opcode 1111111
    pc0 = pc;
    exec(32'h0020_80FF, lat, ic);
    chk("ill_pulses", ic, 1);
    chk("ill_lat", lat, 2);
    chk("ill_pc", pc, pc0 + 4);

    // Reset while LW sits in MEM
    set_reg(1, 6); set_reg(20, 32'hDEAD_BEEF);
    instruction = enc_i(12'd4, 1, 3'b010, 20, 7'b0000011);
    instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midlw_pc", pc, RESET_PC);
    chk("midlw_alu", alu_result, 0);
    chk("midlw_wd", write_data, 0);
    chk("midlw_busy", 32'(busy), 0);
    chk("midlw_ready", 32'(instr_ready), 1);
    @(negedge clk);
    reset = 1'b0;
    m_pc = RESET_PC; m_alu = '0; m_wd = '0; m_wd_known = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("midlw_x20", dut.r_regs[20], 32'hDEAD_BEEF);
    chk("midlw_pc_hold", pc, RESET_PC);

`ifdef RISCV_MC_PERF_EN
    do_reset();
    chk("instret_reset", instret_count, 0);
    for (int k = 0; k < 3; k++) exec(enc_r(7'h00, 3, 2, 3'b000, 1), lat, ic);
    exec(32'h0020_80FF, lat, ic);
    chk("instret_count", instret_count, 3);
    chk("cycle_count", cycle_count, 18);
`endif

    // Randomized phase
    for (int i = 1; i < 32; i++) set_reg(i, $urandom);
    for (int i = 0; i < 64; i++) set_mem(i, $urandom);
    for (int n = 0; n < 400; n++) begin
      exec(rand_instr(), lat, ic);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
